// File: rtl/iter_shift_unit.sv
// Iterative SLL/SRL/SRA unit: shifts up to STEP bits per cycle and returns the result over valid/ready.
// Optional macro ITER_SHIFT_PERF_CNT_EN adds the perf_shift_cycles counter output.
module iter_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
`ifdef ITER_SHIFT_PERF_CNT_EN
    output logic [31:0]        perf_shift_cycles,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0]         OP_SRL   = 2'b01;
    localparam logic [1:0]         OP_SRA   = 2'b11;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [1:0]         op_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;

    logic [SHAMT_W-1:0] k_d;
    logic [SHAMT_W-1:0] rem_d;
    logic [DATA_W-1:0]  data_d;

    // Reserved op 2'b10 falls through to SLL.
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [DATA_W-1:0]  d,
        input logic [SHAMT_W-1:0] k,
        input logic [1:0]         op
    );
        logic signed [DATA_W-1:0] ds;
        ds = $signed(d);
        case (op)
            OP_SRL:  shift_step = d >> k;
            OP_SRA:  shift_step = $unsigned(ds >>> k);
            default: shift_step = d << k;
        endcase
    endfunction

    always_comb begin
        k_d    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        rem_d  = rem_q - k_d;
        data_d = shift_step(data_q, k_d, op_q);
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // out_valid rises one cycle after entering DONE, giving 1 + ceil(shamt/STEP) latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        op_q    <= in_op;
                        rem_q   <= in_shamt;
                        state_q <= (in_shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ITER_SHIFT_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == SHIFT) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_shift_cycles = perf_q;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed, table-driven bench for iter_shift_unit (STEP=4), with hand-written
// backpressure, flush and reset-abort sequences.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef ITER_SHIFT_PERF_CNT_EN
    logic [31:0] perf_shift_cycles;
`endif

    int checks = 0;
    int errors = 0;

    iter_shift_unit #(.DATA_W(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ITER_SHIFT_PERF_CNT_EN
        .perf_shift_cycles (perf_shift_cycles),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, measure edges from accept to out_valid, then complete the handshake.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                          input logic [31:0] e, input int lat, input string name);
        int cnt;
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        in_op     = o;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hA5A5_5A5A;
        in_shamt = 5'd17;
        in_op    = 2'b01;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({name, "_latency"}, cnt, lat);
        check({name, "_data"}, out_data, e);
        tick();
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({name, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 2};
        vecs[1] = '{32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9};
        vecs[2] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9};
        vecs[3] = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1};
        vecs[4] = '{32'h0000_000F, 5'd4,  2'b10, 32'h0000_00F0, 2};
        vecs[5] = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800, 3};
        vecs[6] = '{32'hF000_0000, 5'd5,  2'b11, 32'hFF80_0000, 3};
        vecs[7] = '{32'h7FFF_FFFF, 5'd31, 2'b11, 32'h0000_0000, 9};
        vecs[8] = '{32'hFFFF_FFFF, 5'd1,  2'b01, 32'h7FFF_FFFF, 2};
        vecs[9] = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_shamt = '0; in_op = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
`ifdef ITER_SHIFT_PERF_CNT_EN
        check("rst_perf", perf_shift_cycles, 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].data, vecs[i].shamt, vecs[i].op, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Backpressure with a spurious in_valid held while busy.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd2; in_op = 2'b00; out_ready = 1'b0;
        tick();
        in_data = 32'hFFFF_0000; in_shamt = 5'd3;
        wait_valid("bp");
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'h4);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Flush in the third SHIFT cycle of a shamt=20 op.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd20; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("fl_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        check("fl_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl_valid_later", {31'd0, out_valid}, 32'd0);
        run_op(32'h1, 5'd1, 2'b00, 32'h2, 2, "after_flush");

        // Same abort with rst; out_data also returns to its reset value.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd20; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ra_busy", {31'd0, busy}, 32'd0);
        check("ra_valid", {31'd0, out_valid}, 32'd0);
        check("ra_data", out_data, 32'h0);
        check("ra_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ITER_SHIFT_PERF_CNT_EN
        check("ra_perf", perf_shift_cycles, 32'd0);
`endif
        run_op(32'h1, 5'd1, 2'b00, 32'h2, 2, "after_rst");

`ifdef ITER_SHIFT_PERF_CNT_EN
        begin
            logic [31:0] base;
            base = perf_shift_cycles;
            run_op(32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9, "perf_op");
            check("perf_delta", perf_shift_cycles - base, 32'd8);
        end
`endif

        // Flush coinciding with the result handshake discards it.
        in_valid = 1'b1; in_data = 32'h3; in_shamt = 5'd0; in_op = 2'b00; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid("fh");
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fh_valid", {31'd0, out_valid}, 32'd0);
        check("fh_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
